// File: rtl/uncore_bus_sequencer_pkg.sv
// Shared definitions for the uncore AHB data-phase sequencer and the region decoder.
// Region indices match bit positions of the decoder's one-hot HSELRegions vector.
package uncore_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_t;

  localparam logic [1:0] AHB_HTRANS_NONSEQ = 2'b10;

  localparam int REGION_DTIM    = 10;
  localparam int REGION_IROM    = 9;
  localparam int REGION_EXT     = 8;
  localparam int REGION_BOOTROM = 7;
  localparam int REGION_RAM     = 6;
  localparam int REGION_CLINT   = 5;
  localparam int REGION_GPIO    = 4;
  localparam int REGION_UART    = 3;
  localparam int REGION_PLIC    = 2;
  localparam int REGION_SDC     = 1;
  localparam int REGION_NONE    = 0;

endpackage

// File: rtl/uncore_bus_watchdog.sv
// Stall watchdog for one AHB data phase: counts consecutive not-ready cycles of the
// selected slave and flags expiry on the cycle the count reaches TIMEOUT-1.
module uncore_bus_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic slave_ready,
  output logic expire
);

  localparam bit            WD_EN = (TIMEOUT > 0);
  localparam logic [CNTW-1:0] TERM = WD_EN ? CNTW'(TIMEOUT - 1) : '0;

  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    expire = WD_EN && active && !slave_ready && (cnt_q == TERM);
    // A slave that answers on the expiry cycle wins; the count restarts for the next phase.
    if (!WD_EN || !active || slave_ready || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uncore_bus_sequencer.sv
// AHB-Lite data-phase controller: latches the region select, muxes slave responses
// back to the master and produces the two-cycle ERROR response for unmapped or stalled accesses.
//
// state | meaning
// IDLE  | no data phase in progress, bus ready
// BUSY  | data phase to a mapped slave, ready/data from that slave
// ERR1  | first ERROR cycle, HREADY low
// ERR2  | second ERROR cycle, HREADY high, next address may be accepted
module uncore_bus_sequencer
  import uncore_bus_sequencer_pkg::*;
#(
  parameter int NREGIONS = 11,
  parameter int XLEN     = 64,
  parameter int TIMEOUT  = 1024,
  parameter int CNTW     = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   HTRANS,
  input  logic [NREGIONS-1:0]          HSELRegions,
  input  logic [NREGIONS-2:0]          HREADYOUTS,
  input  logic [(NREGIONS-1)*XLEN-1:0] HRDATAS,
  output logic [NREGIONS-1:0]          HSELD,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [XLEN-1:0]              HRDATA,
  output logic                         TimeoutErr
);

  localparam int IDXW = $clog2(NREGIONS);

  state_t              state_q, state_d;
  logic [NREGIONS-1:0] hseld_q, hseld_d;
  logic [IDXW-1:0]     sel_idx;
  logic [IDXW-1:0]     req_idx;
  logic                sel_ready;
  logic [XLEN-1:0]     sel_rdata;
  logic                accept;
  logic                expire;
  state_t              launch_state;

  // Highest set bit wins so a malformed multi-hot select still picks one slave.
  function automatic logic [IDXW-1:0] top_index(input logic [NREGIONS-1:0] v);
    top_index = '0;
    for (int i = 0; i < NREGIONS; i++) begin
      if (v[i]) top_index = IDXW'(i);
    end
  endfunction

  assign sel_idx = top_index(hseld_q);
  assign req_idx = top_index(HSELRegions);

  always_comb begin
    sel_ready = 1'b1;
    sel_rdata = '0;
    for (int i = 1; i < NREGIONS; i++) begin
      if (sel_idx == IDXW'(i)) begin
        sel_ready = HREADYOUTS[i-1];
        sel_rdata = HRDATAS[(i-1)*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    case (state_q)
      BUSY: begin
        HREADY = sel_ready;
        HRDATA = sel_rdata;
      end
      ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  uncore_bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNTW    (CNTW)
  ) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .active      (state_q == BUSY),
    .slave_ready (sel_ready),
    .expire      (expire)
  );

  assign TimeoutErr   = expire;
  assign accept       = ((HTRANS & AHB_HTRANS_NONSEQ) != 2'b00) && HREADY;
  assign launch_state = (req_idx == IDXW'(REGION_NONE)) ? ERR1 : BUSY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ERR2: state_d = accept ? launch_state : IDLE;
      BUSY: begin
        if (sel_ready)   state_d = accept ? launch_state : IDLE;
        else if (expire) state_d = ERR1;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase

    // An aborted slave is deselected so it cannot complete during the ERROR response.
    if (HREADY)      hseld_d = accept ? HSELRegions : '0;
    else if (expire) hseld_d = '0;
    else             hseld_d = hseld_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hseld_q <= '0;
    end else begin
      state_q <= state_d;
      hseld_q <= hseld_d;
    end
  end

  assign HSELD = hseld_q;

endmodule

// File: tb/tb_uncore_bus_sequencer.sv
// Randomized bench for uncore_bus_sequencer; expected bus behaviour is derived per
// transaction (wait states, ERROR pairs, watchdog expiry) rather than per FSM state.
module tb_uncore_bus_sequencer;
  import uncore_bus_sequencer_pkg::*;

  localparam int NR = 11;
  localparam int XL = 64;
  localparam int TO = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [1:0]             HTRANS;
  logic [NR-1:0]          HSELRegions;
  logic [NR-2:0]          HREADYOUTS;
  logic [(NR-1)*XL-1:0]   HRDATAS;
  logic [NR-1:0]          HSELD;
  logic                   HREADY;
  logic                   HRESP;
  logic [XL-1:0]          HRDATA;
  logic                   TimeoutErr;

  int errors = 0;
  int checks = 0;

  // Expectations for the last data-phase cycle of the previous transfer, which
  // overlaps the next free (address-capable) cycle.
  int            fin_region = 0;
  logic [NR-1:0] fin_sel    = '0;
  logic          fin_resp   = 1'b0;
  logic [XL-1:0] fin_data   = '0;

  uncore_bus_sequencer #(
    .NREGIONS (NR),
    .XLEN     (XL),
    .TIMEOUT  (TO),
    .CNTW     (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .HTRANS      (HTRANS),
    .HSELRegions (HSELRegions),
    .HREADYOUTS  (HREADYOUTS),
    .HRDATAS     (HRDATAS),
    .HSELD       (HSELD),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA),
    .TimeoutErr  (TimeoutErr)
  );

  always #5 clk = ~clk;

  function automatic logic [NR-1:0] onehot(input int r);
    onehot    = '0;
    onehot[r] = 1'b1;
  endfunction

  function automatic logic [XL-1:0] rnd64();
    rnd64 = {$urandom, $urandom};
  endfunction

  task automatic drive_noise();
    HREADYOUTS = (NR-1)'($urandom);
    for (int i = 0; i < NR-1; i++) HRDATAS[i*XL +: XL] = rnd64();
  endtask

  task automatic clear_fin();
    fin_region = 0;
    fin_sel    = '0;
    fin_resp   = 1'b0;
    fin_data   = '0;
  endtask

  // One bus cycle: entered just after a rising edge, drives, checks mid-cycle, returns after the next edge.
  task automatic bus_cycle(input string tag, input logic trans, input logic [NR-1:0] sel_in,
                           input int drv_region, input logic drv_rdy, input logic [XL-1:0] drv_data,
                           input logic e_rdy, input logic e_resp, input logic e_to,
                           input logic [NR-1:0] e_sel, input logic [XL-1:0] e_data);
    drive_noise();
    HTRANS      = trans ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
    HSELRegions = sel_in;
    if (drv_region > 0) begin
      HREADYOUTS[drv_region-1]           = drv_rdy;
      HRDATAS[(drv_region-1)*XL +: XL]   = drv_data;
    end
    #4;
    checks++;
    if ({HREADY, HRESP, TimeoutErr} !== {e_rdy, e_resp, e_to}) begin
      errors++;
      $display("FAIL %s ready/resp/timeout: got %b%b%b want %b%b%b @%0t",
               tag, HREADY, HRESP, TimeoutErr, e_rdy, e_resp, e_to, $time);
    end
    checks++;
    if (HSELD !== e_sel) begin
      errors++;
      $display("FAIL %s HSELD: got %h want %h @%0t", tag, HSELD, e_sel, $time);
    end
    checks++;
    if (HRDATA !== e_data) begin
      errors++;
      $display("FAIL %s HRDATA: got %h want %h @%0t", tag, HRDATA, e_data, $time);
    end
    @(posedge clk);
    #1;
  endtask

  // A cycle in which the bus must be ready; it may carry a new address phase.
  task automatic free_cycle(input logic trans, input int region);
    logic [NR-1:0] s;
    s = trans ? onehot(region) : onehot($urandom_range(0, NR-1));
    bus_cycle("free", trans, s, fin_region, 1'b1, fin_data,
              1'b1, fin_resp, 1'b0, fin_sel, fin_data);
    clear_fin();
  endtask

  // Transfer to region (0 = unmapped) whose slave waits `stall` cycles (stall < TO).
  task automatic txn(input int region, input int stall, input logic [XL-1:0] d);
    free_cycle(1'b1, region);
    if (region == REGION_NONE) begin
      bus_cycle("err1", 1'($urandom), onehot($urandom_range(0, NR-1)), 0, 1'b0, '0,
                1'b0, 1'b1, 1'b0, onehot(0), '0);
      fin_region = 0;
      fin_sel    = onehot(0);
      fin_resp   = 1'b1;
      fin_data   = '0;
    end else begin
      for (int k = 0; k < stall; k++) begin
        bus_cycle("stall", 1'($urandom), onehot($urandom_range(0, NR-1)), region, 1'b0, d,
                  1'b0, 1'b0, 1'b0, onehot(region), d);
      end
      fin_region = region;
      fin_sel    = onehot(region);
      fin_resp   = 1'b0;
      fin_data   = d;
    end
  endtask

  // Transfer whose slave never answers: TO stall cycles, pulse on the last, then ERROR pair.
  task automatic txn_timeout(input int region, input logic [XL-1:0] d);
    free_cycle(1'b1, region);
    for (int k = 1; k <= TO; k++) begin
      bus_cycle("wd_stall", 1'($urandom), onehot($urandom_range(0, NR-1)), region, 1'b0, d,
                1'b0, 1'b0, (k == TO), onehot(region), d);
    end
    bus_cycle("wd_err1", 1'($urandom), onehot($urandom_range(0, NR-1)), 0, 1'b0, '0,
              1'b0, 1'b1, 1'b0, '0, '0);
    fin_region = 0;
    fin_sel    = '0;
    fin_resp   = 1'b1;
    fin_data   = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) free_cycle(1'b0, 0);
    reset = 1'b0;
    repeat (2) free_cycle(1'b0, 0);
  endtask

  task automatic test_mapped_read();
    txn(REGION_UART, 2, 64'h0000_0000_DEAD_BEEF);
    free_cycle(1'b0, 0);
    for (int n = 0; n < 4; n++) begin
      txn($urandom_range(1, NR-1), $urandom_range(0, 5), rnd64());
      free_cycle(1'b0, 0);
    end
  endtask

  task automatic test_unmapped();
    txn(REGION_NONE, 0, '0);
    txn(REGION_CLINT, 0, rnd64());
    free_cycle(1'b0, 0);
    txn(REGION_NONE, 0, '0);
    txn(REGION_NONE, 0, '0);
    free_cycle(1'b0, 0);
  endtask

  task automatic test_watchdog();
    txn_timeout(REGION_RAM, rnd64());
    free_cycle(1'b0, 0);
    txn(REGION_RAM, TO - 1, rnd64());
    free_cycle(1'b0, 0);
    txn_timeout(REGION_GPIO, rnd64());
    txn(REGION_GPIO, 1, rnd64());
    free_cycle(1'b0, 0);
  endtask

  task automatic test_back_to_back();
    txn(REGION_BOOTROM, 0, rnd64());
    txn(REGION_EXT, 0, rnd64());
    txn(REGION_IROM, 0, rnd64());
    txn(REGION_DTIM, 0, rnd64());
    free_cycle(1'b0, 0);
  endtask

  task automatic test_random_traffic();
    for (int t = 0; t < 40; t++) begin
      int region;
      int gap;
      int pick;
      region = $urandom_range(0, NR-1);
      gap    = $urandom_range(0, 2);
      pick   = $urandom_range(0, 9);
      repeat (gap) free_cycle(1'b0, 0);
      if (region != REGION_NONE && pick == 0) txn_timeout(region, rnd64());
      else if (pick < 6) txn(region, $urandom_range(0, 2), rnd64());
      else txn(region, $urandom_range(3, TO - 1), rnd64());
    end
    free_cycle(1'b0, 0);
  endtask

  task automatic test_reset_mid_stall();
    txn(REGION_RAM, TO - 1, rnd64());
    // Interrupt the still-stalled data phase with a one-cycle reset.
    drive_noise();
    HREADYOUTS[REGION_RAM-1] = 1'b0;
    HTRANS      = AHB_HTRANS_NONSEQ;
    HSELRegions = onehot(REGION_GPIO);
    reset       = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_fin();
    repeat (3) free_cycle(1'b0, 0);
  endtask

  task automatic test_reset_mid_error();
    free_cycle(1'b1, REGION_NONE);
    drive_noise();
    HTRANS      = 2'b00;
    HSELRegions = '0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_fin();
    repeat (2) free_cycle(1'b0, 0);
    txn(REGION_SDC, 1, rnd64());
    free_cycle(1'b0, 0);
  endtask

  initial begin
    reset       = 1'b1;
    HTRANS      = 2'b00;
    HSELRegions = '0;
    HREADYOUTS  = '0;
    HRDATAS     = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_mapped_read();
    test_unmapped();
    test_watchdog();
    test_back_to_back();
    test_random_traffic();
    test_reset_mid_stall();
    test_reset_mid_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
